// File: rtl/pipe_operand_loader_pkg.sv
// Shared defaults and the result-entry layout for the operand loader.
package pipe_pkg;

   localparam int N_DEF     = 10;  // operand / result width
   localparam int LAT_DEF   = 3;   // pipe_ex depth in clock edges
   localparam int DEPTH_DEF = 4;   // result FIFO entries == in-flight credit limit
   localparam int TAG_W_DEF = 4;   // sequence tag width

   // One captured result: pipe_ex output plus the tag of the quad that produced it.
   typedef struct packed {
      logic [N_DEF-1:0]     data;
      logic [TAG_W_DEF-1:0] tag;
   } res_entry_t;

endpackage

// File: rtl/pipe_operand_loader_res_fifo.sv
// Small synchronous FIFO holding captured results until the consumer pops them.
module res_fifo
   import pipe_pkg::*;
#(
   parameter int  DEPTH = DEPTH_DEF,
   parameter type T     = res_entry_t,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  T              i_wdata,
   input  logic          i_pop,
   output T              o_rdata,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   // Pop on an empty FIFO is a no-op; the loader's credit scheme keeps pushes off a full one.
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && !o_full;

   assign o_rdata = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

   // Storage, wrap-around pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= i_wdata;
            r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
         end
         if (w_do_pop)
            r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pipe_operand_loader.sv
// Gathers operand words into A..D quads, issues them to pipe_ex, tracks the
// pipeline latency with a valid/tag delay line and collects aligned results.
module pipe_operand_loader
   import pipe_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LAT   = LAT_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N-1:0]     A,
   output logic [N-1:0]     B,
   output logic [N-1:0]     C,
   output logic [N-1:0]     D,
   output logic             issue,
   input  logic [N-1:0]     F_in,
   output logic [N-1:0]     res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   // Entry layout mirrors pipe_pkg::res_entry_t but follows this instance's widths.
   typedef struct packed {
      logic [N-1:0]     data;
      logic [TAG_W-1:0] tag;
   } ent_t;

   logic [N-1:0]     r_g [4];
   logic [1:0]       r_wptr;
   logic             r_pend;
   logic [TAG_W-1:0] r_seq;
   logic [TAG_W-1:0] r_itag;
   logic [CW-1:0]    r_inflight;
   logic [LAT-1:0]   r_vld;
   logic [TAG_W-1:0] r_tag [LAT];

   logic             w_accept;
   logic             w_issue;
   logic             w_push;
   logic [CW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;
   ent_t             w_wdata;
   ent_t             w_rdata;

   assign in_ready = ~r_pend;
   assign w_accept = in_valid & ~r_pend;
   // Credit: every issued quad owns a FIFO slot from issue until it is popped.
   assign w_issue  = r_pend && ((int'(r_inflight) + int'(w_count)) < DEPTH);
   assign w_push   = r_vld[LAT-1];
   assign w_wdata  = '{data: F_in, tag: r_tag[LAT-1]};

   assign res_valid = ~w_empty;
   assign res_data  = w_rdata.data;
   assign res_tag   = w_rdata.tag;

   // Gather accepted words into slots g0..g3; a full quad blocks input until issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_pend <= 1'b0;
         for (int i = 0; i < 4; i++) r_g[i] <= '0;
      end else begin
         if (w_accept) begin
            r_g[r_wptr] <= in_data;
            r_wptr      <= r_wptr + 2'd1;
         end
         if (w_accept && (r_wptr == 2'd3)) r_pend <= 1'b1;
         else if (w_issue)                 r_pend <= 1'b0;
      end
   end

   // Issue register: load A..D, pulse issue and stamp the quad with the next sequence tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         A      <= '0;
         B      <= '0;
         C      <= '0;
         D      <= '0;
         issue  <= 1'b0;
         r_itag <= '0;
         r_seq  <= '0;
      end else begin
         issue <= w_issue;
         if (w_issue) begin
            A      <= r_g[0];
            B      <= r_g[1];
            C      <= r_g[2];
            D      <= r_g[3];
            r_itag <= r_seq;
            r_seq  <= r_seq + TAG_W'(1);
         end
      end
   end

   // Valid/tag delay line shadowing pipe_ex so only issue-aligned F values are captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
      end else begin
         r_vld[0] <= issue;
         r_tag[0] <= r_itag;
         for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // Quads issued but not yet landed in the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue, w_push})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   res_fifo #(
      .DEPTH (DEPTH),
      .T     (ent_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (res_ready),
      .o_rdata (w_rdata),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A push while full would lose a result; the credit rule makes this unreachable.
   assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule
